rr_sel_arbiter: RTL

Round-robin controller that shares the 4:1 two-bit select datapath among four requesters. Each requester presents its data word on one of inputs `a`..`d` and raises its `req` bit. The block generates the mux select, a one-hot grant and a valid/ready output handshake. No requester may hold the shared output for more than `MAX_HOLD` consecutive transfers while others are waiting.

---
 rtl/rr_sel_pkg.sv | 33 +++
 rtl/mux4_sel.sv | 24 ++
 rtl/rr_sel_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/rr_sel_pkg.sv
// Shared types and the round-robin search used by the rr_sel_arbiter slice.
package rr_sel_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan downward so the lowest offset from start is the one left standing.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   start);
    pick_t            p;
    logic [IDX_W-1:0] idx;
    p = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = start + IDX_W'(i);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_sel.sv
// Plain 4:1 word mux; output gating is left to the instantiating block.
module mux4_sel
  import rr_sel_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic [IDX_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] in0_i,
  input  logic [DATA_W-1:0] in1_i,
  input  logic [DATA_W-1:0] in2_i,
  input  logic [DATA_W-1:0] in3_i,
  output logic [DATA_W-1:0] out_o
);

  always_comb begin
    case (sel_i)
      2'd0:    out_o = in0_i;
      2'd1:    out_o = in1_i;
      2'd2:    out_o = in2_i;
      default: out_o = in3_i;
    endcase
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin owner of the shared 4:1 select path with a per-grant transfer
// quota and a valid/ready handshake toward the downstream consumer.
module rr_sel_arbiter
  import rr_sel_pkg::*;
#(
  parameter int DATA_W   = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [DATA_W-1:0]  c,
  input  logic [DATA_W-1:0]  d,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic [DATA_W-1:0]  data,
  output logic               valid
);

  localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  logic               xfer;
  logic               arb_en;
  pick_t              pick;
  logic [DATA_W-1:0]  mux_out;

  assign valid = (state_q == GRANT);
  assign xfer  = valid & out_ready;
  assign sel   = sel_q;
  assign grant = grant_q;

  // ptr always equals the current grantee while granted, so one search start
  // serves both the idle pick and the same-edge re-arbitration on release.
  assign pick = rr_pick(req, ptr_q + IDX_W'(1));

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves a
    // combinational output unassigned and infers a latch.
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    arb_en  = 1'b0;

    case (state_q)
      IDLE: arb_en = 1'b1;
      GRANT: begin
        if (!req[sel_q] || (xfer && (hold_q == HOLD_LAST))) begin
          arb_en = 1'b1;
        end else if (xfer) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_en) begin
      if (pick.found) begin
        state_d = GRANT;
        sel_d   = pick.idx;
        ptr_d   = pick.idx;
        grant_d = NUM_REQ'(1) << pick.idx;
        hold_d  = '0;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers update with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  mux4_sel #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel_i (sel_q),
    .in0_i (a),
    .in1_i (b),
    .in2_i (c),
    .in3_i (d),
    .out_o (mux_out)
  );

  assign data = valid ? mux_out : '0;

endmodule
